// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin IF/LS arbiter for the shared memory read port
// Grants one read per cycle and routes mem_rdata back via a MEM_LATENCY-deep tag pipeline.
module mem_read_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ls_req_valid,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_req_ready,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_enable,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic                   last_ls_q, last_ls_d;
  logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LATENCY-1:0] tag_ls_q, tag_ls_d;
  logic                   grant_if, grant_ls;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!rst) begin
      if (if_req_valid && ls_req_valid) begin
        grant_if = last_ls_q;
        grant_ls = !last_ls_q;
      end else begin
        grant_if = if_req_valid;
        grant_ls = ls_req_valid;
      end
    end
  end

  always_comb begin
    last_ls_d = last_ls_q;
    if (grant_if) begin
      last_ls_d = 1'b0;
    end else if (grant_ls) begin
      last_ls_d = 1'b1;
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_ls_d     = '0;
    tag_vld_d[0] = grant_if || grant_ls;
    tag_ls_d[0]  = grant_ls;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ls_d[i]  = tag_ls_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls_q <= 1'b1;
      tag_vld_q <= '0;
      tag_ls_q  <= '0;
    end else begin
      last_ls_q <= last_ls_d;
      tag_vld_q <= tag_vld_d;
      tag_ls_q  <= tag_ls_d;
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign mem_r_enable = grant_if || grant_ls;
  assign mem_addr     = grant_if ? if_req_addr : (grant_ls ? ls_req_addr : '0);

  // Masked during rst so a read landing in the reset cycle is dropped too.
  assign if_resp_valid = !rst && tag_vld_q[MEM_LATENCY-1] && !tag_ls_q[MEM_LATENCY-1];
  assign ls_resp_valid = !rst && tag_vld_q[MEM_LATENCY-1] &&  tag_ls_q[MEM_LATENCY-1];
  assign if_resp_data  = mem_rdata;
  assign ls_resp_data  = mem_rdata;

endmodule
